// File: rtl/turn_controller_pkg.sv
// rtl/turn_controller_pkg.sv - shared state and player encodings for the chess clock game flow
// Purpose: state enum for the turn FSM, player codes shared with the timer-control
//          stage, and decode helpers used to build the registered outputs.
// Ports:   none (package).
package turn_controller_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN1   = 3'd1,
    S_RUN2   = 3'd2,
    S_PAUSE1 = 3'd3,
    S_PAUSE2 = 3'd4,
    S_OVER   = 3'd5
  } state_t;

  // Must stay identical to the codes decoded by the timer-control stage.
  localparam logic [1:0] P_NONE = 2'b00;
  localparam logic [1:0] P_ONE  = 2'b01;
  localparam logic [1:0] P_TWO  = 2'b10;

  function automatic logic [1:0] player_of(input state_t s);
    case (s)
      S_RUN1, S_PAUSE1: player_of = P_ONE;
      S_RUN2, S_PAUSE2: player_of = P_TWO;
      default:          player_of = P_NONE;
    endcase
  endfunction

  function automatic logic enable_of(input state_t s);
    enable_of = (s == S_RUN1) || (s == S_RUN2);
  endfunction

endpackage

// File: rtl/turn_controller_button_conditioner.sv
// rtl/turn_controller_button_conditioner.sv - synchronizer, debouncer and rising-edge press detector for one raw button
// Purpose: bring a raw push-button into the clock domain, accept a level change only
//          after it has been stable for DEBOUNCE_CYCLES edges, and emit a one-cycle
//          press pulse on each debounced rising edge.
// Ports:   clk    - system clock
//          reset  - asynchronous active-high reset
//          raw    - raw button level
//          press  - one-cycle pulse on debounced press
module button_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1; the final edge commits the level.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   stable;
  logic                   stable_d;
  logic [CNT_W-1:0]       cnt;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
    end else begin
      stable_d <= stable;
      if (s == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= s;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = stable & ~stable_d;

endmodule

// File: rtl/turn_controller.sv
// rtl/turn_controller.sv - game-flow master of the chess clock
// Purpose: conditions the four push-buttons, runs the turn/pause/game-over FSM and
//          drives the timer enable and active player, counting completed handovers.
// Ports:   clk, reset (async, active-high)
//          btn_p1, btn_p2, btn_start, btn_new - raw push-buttons
//          timeout1, timeout2                 - per-player time exhausted flags
//          enable, player[1:0]                - timer run control
//          game_over, loser[1:0]              - result of a timeout
//          move_count[MOVE_W-1:0]             - saturating handover count
module turn_controller
  import turn_controller_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int MOVE_W          = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_p1,
  input  logic              btn_p2,
  input  logic              btn_start,
  input  logic              btn_new,
  input  logic              timeout1,
  input  logic              timeout2,
  output logic              enable,
  output logic [1:0]        player,
  output logic              game_over,
  output logic [1:0]        loser,
  output logic [MOVE_W-1:0] move_count
);

  logic p1_press, p2_press, start_press, new_press;

  button_conditioner #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_p1 (
    .clk(clk), .reset(reset), .raw(btn_p1), .press(p1_press));
  button_conditioner #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_p2 (
    .clk(clk), .reset(reset), .raw(btn_p2), .press(p2_press));
  button_conditioner #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_start (
    .clk(clk), .reset(reset), .raw(btn_start), .press(start_press));
  button_conditioner #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_new (
    .clk(clk), .reset(reset), .raw(btn_new), .press(new_press));

  state_t            state, state_n;
  logic [1:0]        loser_n;
  logic [MOVE_W-1:0] moves_n;
  logic [MOVE_W-1:0] moves_inc;

  // Saturate rather than wrap so a long game never reads as a short one.
  assign moves_inc = (move_count == {MOVE_W{1'b1}}) ? move_count : move_count + MOVE_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Priority: new game, then timeout, then active player's handover, then start.
  always_comb begin
    state_n = state;
    loser_n = loser;
    moves_n = move_count;
    if (new_press) begin
      state_n = S_IDLE;
      loser_n = P_NONE;
      moves_n = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_press) state_n = S_RUN1;
        end
        S_RUN1: begin
          if (timeout1) begin
            state_n = S_OVER;
            loser_n = P_ONE;
          end else if (p1_press) begin
            state_n = S_RUN2;
            moves_n = moves_inc;
          end else if (start_press) begin
            state_n = S_PAUSE1;
          end
        end
        S_RUN2: begin
          if (timeout2) begin
            state_n = S_OVER;
            loser_n = P_TWO;
          end else if (p2_press) begin
            state_n = S_RUN1;
            moves_n = moves_inc;
          end else if (start_press) begin
            state_n = S_PAUSE2;
          end
        end
        S_PAUSE1: begin
          if (start_press) state_n = S_RUN1;
        end
        S_PAUSE2: begin
          if (start_press) state_n = S_RUN2;
        end
        S_OVER: begin
          state_n = S_OVER;
        end
        default: begin
          state_n = S_IDLE;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they align with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable     <= 1'b0;
      player     <= P_NONE;
      game_over  <= 1'b0;
      loser      <= P_NONE;
      move_count <= '0;
    end else begin
      enable     <= enable_of(state_n);
      player     <= player_of(state_n);
      game_over  <= (state_n == S_OVER);
      loser      <= loser_n;
      move_count <= moves_n;
    end
  end

endmodule

// File: tb/tb_turn_controller.sv
// tb/tb_turn_controller.sv - self-checking bench for turn_controller
module tb_turn_controller;

  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int MOVE_W          = 2;
  localparam int LAT             = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
  localparam int MAX_MOVES       = (1 << MOVE_W) - 1;

  // Button selectors used by the stimulus tasks and the model.
  localparam int B_P1 = 0, B_P2 = 1, B_START = 2, B_NEW = 3, B_BOTH = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic              btn_p1, btn_p2, btn_start, btn_new;
  logic              timeout1, timeout2;
  logic              enable;
  logic [1:0]        player;
  logic              game_over;
  logic [1:0]        loser;
  logic [MOVE_W-1:0] move_count;

  int total = 0;
  int bad   = 0;

  // Game model: phase 0 idle, 1 running, 2 paused, 3 over; turn is 1 or 2.
  int m_phase, m_turn, m_moves, m_loser;

  turn_controller #(
    .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .MOVE_W(MOVE_W)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_p1(btn_p1), .btn_p2(btn_p2), .btn_start(btn_start), .btn_new(btn_new),
    .timeout1(timeout1), .timeout2(timeout2),
    .enable(enable), .player(player), .game_over(game_over), .loser(loser),
    .move_count(move_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_phase = 0; m_turn = 1; m_moves = 0; m_loser = 0;
  endtask

  task automatic model_button(input int b);
    if (b == B_NEW) begin
      model_reset();
    end else if (b == B_START) begin
      if (m_phase == 0) begin m_phase = 1; m_turn = 1; end
      else if (m_phase == 1) m_phase = 2;
      else if (m_phase == 2) m_phase = 1;
    end else if (m_phase == 1 && (b == B_BOTH || b + 1 == m_turn)) begin
      m_turn  = 3 - m_turn;
      m_moves = (m_moves < MAX_MOVES) ? m_moves + 1 : MAX_MOVES;
    end
  endtask

  task automatic model_timeout(input int k);
    if (m_phase == 1 && m_turn == k) begin
      m_phase = 3;
      m_loser = k;
    end
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      B_P1:    btn_p1 = v;
      B_P2:    btn_p2 = v;
      B_START: btn_start = v;
      B_NEW:   btn_new = v;
      default: begin btn_p1 = v; btn_p2 = v; end
    endcase
  endtask

  // Clean press: held long enough to register, then released and allowed to settle.
  task automatic push(input int b);
    @(negedge clk);
    set_btn(b, 1'b1);
    repeat (LAT) @(posedge clk);
    #1;
    set_btn(b, 1'b0);
    repeat (LAT + 1) @(posedge clk);
    #1;
    model_button(b);
  endtask

  task automatic pulse_timeout(input int k);
    @(negedge clk);
    if (k == 1) timeout1 = 1'b1; else timeout2 = 1'b1;
    @(posedge clk);
    #1;
    timeout1 = 1'b0;
    timeout2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_timeout(k);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    btn_p1 = 0; btn_p2 = 0; btn_start = 0; btn_new = 0; timeout1 = 0; timeout2 = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (enable !== 1'b0) begin bad++; $display("FAIL reset_enable: got %0h want 0", enable); end
    total++; if (player !== 2'b00) begin bad++; $display("FAIL reset_player: got %0h want 0", player); end
    total++; if (game_over !== 1'b0) begin bad++; $display("FAIL reset_game_over: got %0h want 0", game_over); end
    total++; if (loser !== 2'b00) begin bad++; $display("FAIL reset_loser: got %0h want 0", loser); end
    total++; if (move_count !== '0) begin bad++; $display("FAIL reset_moves: got %0h want 0", move_count); end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_start_latency();
    @(negedge clk);
    btn_start = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    #1;
    total++; if (enable !== 1'b0) begin bad++; $display("FAIL start_early: enable got %0h want 0 at edge %0d", enable, LAT - 1); end
    @(posedge clk);
    #1;
    total++; if (enable !== 1'b1) begin bad++; $display("FAIL start_enable: got %0h want 1 at edge %0d", enable, LAT); end
    total++; if (player !== 2'b01) begin bad++; $display("FAIL start_player: got %0h want 1", player); end
    total++; if (game_over !== 1'b0) begin bad++; $display("FAIL start_game_over: got %0h want 0", game_over); end
    total++; if (move_count !== 0) begin bad++; $display("FAIL start_moves: got %0h want 0", move_count); end
    btn_start = 1'b0;
    repeat (LAT + 1) @(posedge clk);
    #1;
    model_button(B_START);
  endtask

  task automatic test_handover();
    push(B_P2);
    total++; if (player !== 2'b01 || move_count !== 0) begin bad++; $display("FAIL wrong_player: player %0h moves %0h want 1 0", player, move_count); end
    push(B_P1);
    total++; if (player !== 2'b10 || move_count !== 1) begin bad++; $display("FAIL handover1: player %0h moves %0h want 2 1", player, move_count); end
    push(B_P2);
    total++; if (player !== 2'b01 || move_count !== 2) begin bad++; $display("FAIL handover2: player %0h moves %0h want 1 2", player, move_count); end
  endtask

  task automatic test_bounce();
    repeat (5) begin
      @(negedge clk);
      btn_p1 = 1'b1;
      repeat (DEBOUNCE_CYCLES - 1) @(posedge clk);
      @(negedge clk);
      btn_p1 = 1'b0;
      repeat (DEBOUNCE_CYCLES - 1) @(posedge clk);
    end
    repeat (LAT + 1) @(posedge clk);
    #1;
    total++; if (player !== 2'b01 || move_count !== 2) begin bad++; $display("FAIL bounce: player %0h moves %0h want 1 2", player, move_count); end
    push(B_P1);
    total++; if (player !== 2'b10 || move_count !== 3) begin bad++; $display("FAIL bounce_held: player %0h moves %0h want 2 3", player, move_count); end
  endtask

  task automatic test_pause();
    push(B_START);
    total++; if (enable !== 1'b0 || player !== 2'b10) begin bad++; $display("FAIL pause: enable %0h player %0h want 0 2", enable, player); end
    push(B_P2);
    total++; if (enable !== 1'b0 || player !== 2'b10 || move_count !== 3) begin bad++; $display("FAIL pause_press: enable %0h player %0h moves %0h want 0 2 3", enable, player, move_count); end
    pulse_timeout(2);
    total++; if (game_over !== 1'b0) begin bad++; $display("FAIL pause_timeout: game_over %0h want 0", game_over); end
    push(B_START);
    total++; if (enable !== 1'b1 || player !== 2'b10) begin bad++; $display("FAIL resume: enable %0h player %0h want 1 2", enable, player); end
  endtask

  task automatic test_timeout_priority();
    push(B_NEW);
    total++; if (move_count !== 0 || player !== 2'b00 || enable !== 1'b0) begin bad++; $display("FAIL new_game: moves %0h player %0h enable %0h want 0 0 0", move_count, player, enable); end
    push(B_START);
    push(B_P1);
    push(B_P2);
    // Raise timeout1 for exactly the cycle in which p1's press pulse is live.
    @(negedge clk);
    btn_p1 = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    #1;
    timeout1 = 1'b1;
    @(posedge clk);
    #1;
    timeout1 = 1'b0;
    btn_p1 = 1'b0;
    total++; if (game_over !== 1'b1) begin bad++; $display("FAIL to_game_over: got %0h want 1", game_over); end
    total++; if (loser !== 2'b01) begin bad++; $display("FAIL to_loser: got %0h want 1", loser); end
    total++; if (enable !== 1'b0 || player !== 2'b00) begin bad++; $display("FAIL to_outputs: enable %0h player %0h want 0 0", enable, player); end
    total++; if (move_count !== 2) begin bad++; $display("FAIL to_moves: got %0h want 2", move_count); end
    repeat (LAT + 1) @(posedge clk);
    model_timeout(1);
    push(B_START);
    total++; if (game_over !== 1'b1 || enable !== 1'b0) begin bad++; $display("FAIL over_start: game_over %0h enable %0h want 1 0", game_over, enable); end
    push(B_NEW);
    total++; if (game_over !== 0 || loser !== 0 || enable !== 0 || player !== 0 || move_count !== 0) begin
      bad++; $display("FAIL over_new: go %0h loser %0h en %0h pl %0h mv %0h want all 0", game_over, loser, enable, player, move_count);
    end
  endtask

  task automatic test_saturation_and_reset();
    push(B_START);
    for (int i = 0; i < 5; i++) push((i % 2 == 0) ? B_P1 : B_P2);
    total++; if (move_count !== 2'd3 || player !== 2'b10) begin bad++; $display("FAIL saturate: moves %0h player %0h want 3 2", move_count, player); end
    // Leave a start press mid-debounce, then reset between edges.
    @(negedge clk);
    btn_start = 1'b1;
    repeat (LAT - 2) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    total++; if (enable !== 0 || player !== 0 || move_count !== 0 || game_over !== 0 || loser !== 0) begin
      bad++; $display("FAIL async_reset: en %0h pl %0h mv %0h go %0h loser %0h want all 0", enable, player, move_count, game_over, loser);
    end
    btn_start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (3 * LAT) @(posedge clk);
    #1;
    total++; if (enable !== 0 || player !== 0) begin bad++; $display("FAIL reset_pending: en %0h pl %0h want 0 0", enable, player); end
  endtask

  task automatic test_random();
    int act;
    for (int n = 0; n < 60; n++) begin
      act = $urandom_range(0, 7);
      if (act == B_NEW && $urandom_range(0, 3) != 0) act = B_START;
      case (act)
        4: pulse_timeout(1);
        5: pulse_timeout(2);
        7: begin
          @(negedge clk);
          btn_p1 = 1'b1; btn_p2 = 1'b1;
          repeat (DEBOUNCE_CYCLES - 1) @(posedge clk);
          @(negedge clk);
          btn_p1 = 1'b0; btn_p2 = 1'b0;
          repeat (LAT + 1) @(posedge clk);
          #1;
        end
        default: push(act);
      endcase
      total++; if (enable !== (m_phase == 1)) begin bad++; $display("FAIL rand_enable step %0d act %0d: got %0h want %0h", n, act, enable, m_phase == 1); end
      total++; if (player !== ((m_phase == 1 || m_phase == 2) ? m_turn : 0)) begin bad++; $display("FAIL rand_player step %0d act %0d: got %0h want %0h", n, act, player, (m_phase == 1 || m_phase == 2) ? m_turn : 0); end
      total++; if (game_over !== (m_phase == 3)) begin bad++; $display("FAIL rand_game_over step %0d: got %0h want %0h", n, game_over, m_phase == 3); end
      total++; if (loser !== m_loser) begin bad++; $display("FAIL rand_loser step %0d: got %0h want %0h", n, loser, m_loser); end
      total++; if (move_count !== m_moves) begin bad++; $display("FAIL rand_moves step %0d: got %0h want %0h", n, move_count, m_moves); end
    end
  endtask

  initial begin
    test_reset();
    test_start_latency();
    test_handover();
    test_bounce();
    test_pause();
    test_timeout_priority();
    test_saturation_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
